fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async-FIFO write port among NUM_REQ write-domain producers.
// Optional statistics outputs (xfer_count, stall_count) are built when ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_wr_data,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
`ifdef ARB_STATS_EN
    output logic [15:0]                xfer_count,
    output logic [15:0]                stall_count,
`endif
    output logic                       dbg_state,
    output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, sel_id;
    logic [BW-1:0]  beat_cnt, beat_nxt;
    logic           sel_found, hold_valid, xfer, last_beat;

    // Search starts just after the last releaser, so it has lowest priority.
    always_comb begin
        logic [IDW-1:0] idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    // A beat moves only when req_valid[i] & req_ready[i] are both high at the rising
    // edge; ready never depends on valid, and fifo_wr_en is exactly that product.
    assign hold_valid = req_valid[grant_id];
    assign xfer       = (state == BURST) & hold_valid & ~fifo_full;
    assign last_beat  = (beat_cnt == BW'(BURST_LEN - 1));

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = BURST;
                    grant_nxt = sel_id;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                // A full FIFO with valid high simply holds everything.
                if (!hold_valid) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_id;
                end else if (xfer) begin
                    if (last_beat) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_id;
                    end else begin
                        beat_nxt = beat_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        grant_valid  = (state == BURST);
        if (state == BURST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == IDW'(i)) fifo_wr_data = req_data[i*DATA_W +: DATA_W];
            end
            // Reset masks handshakes in the very cycle it is sampled.
            if (!wr_rst && !fifo_full) begin
                req_ready[grant_id] = 1'b1;
                fifo_wr_en          = hold_valid;
            end
        end
    end

    assign dbg_state  = (state == BURST);
    assign dbg_rr_ptr = rr_ptr;

`ifdef ARB_STATS_EN
    logic stall;
    assign stall = (state == BURST) & hold_valid & fifo_full;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (xfer) xfer_count <= xfer_count + 16'd1;
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int IDW       = 2;

    logic                      wr_clk = 1'b0;
    logic                      wr_rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      grant_valid;
    logic [IDW-1:0]            grant_id;
    logic                      dbg_state;
    logic [IDW-1:0]            dbg_rr_ptr;
`ifdef ARB_STATS_EN
    logic [15:0]               xfer_count;
    logic [15:0]               stall_count;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
`ifdef ARB_STATS_EN
        .xfer_count   (xfer_count),
        .stall_count  (stall_count),
`endif
        .dbg_state    (dbg_state),
        .dbg_rr_ptr   (dbg_rr_ptr)
    );

    always #5 wr_clk = ~wr_clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0]  dq [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold_off;
    logic [NUM_REQ-1:0] acc_mask;
    logic [DATA_W-1:0]  wr_log[$];
    logic [IDW-1:0]     gnt_log[$];
    logic [IDW-1:0]     rr_log[$];
    logic               en_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    initial begin
        int owner, last, gid, beats, c;
        logic [15:0]        m_xfer, m_stall;
        logic               prev_gv, own_v, e_wren;
        logic [NUM_REQ-1:0] e_ready;
        logic [DATA_W-1:0]  e_data;
        owner = -1; last = NUM_REQ - 1; gid = 0; beats = 0;
        m_xfer = '0; m_stall = '0; prev_gv = 1'b0; acc_mask = '0;
        @(posedge wr_clk);
        forever begin
            @(negedge wr_clk);
            e_ready = '0; e_wren = 1'b0; e_data = '0; own_v = 1'b0;
            if (owner >= 0) begin
                own_v = req_valid[IDW'(owner)];
                for (int j = 0; j < NUM_REQ; j++)
                    if (j == owner) e_data = req_data[j*DATA_W +: DATA_W];
                if (!wr_rst && !fifo_full) begin
                    e_ready[IDW'(owner)] = 1'b1;
                    e_wren = own_v;
                end
            end
            check("req_ready",    32'(req_ready),    32'(e_ready));
            check("fifo_wr_en",   32'(fifo_wr_en),   32'(e_wren));
            check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
            check("grant_valid",  32'(grant_valid),  32'(owner >= 0));
            check("grant_id",     32'(grant_id),     32'(gid));
            check("state",        32'(dbg_state),    32'(owner >= 0));
            check("rr_ptr",       32'(dbg_rr_ptr),   32'(last));
`ifdef ARB_STATS_EN
            check("xfer_count",   32'(xfer_count),   32'(m_xfer));
            check("stall_count",  32'(stall_count),  32'(m_stall));
`endif
            en_log.push_back(fifo_wr_en);
            if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
            if (grant_valid && !prev_gv) begin
                gnt_log.push_back(grant_id);
                rr_log.push_back(dbg_rr_ptr);
            end
            prev_gv  = grant_valid;
            acc_mask = req_valid & e_ready;

            if (wr_rst) begin
                m_xfer = '0; m_stall = '0;
                owner = -1; last = NUM_REQ - 1; gid = 0; beats = 0;
            end else begin
                if (e_wren) m_xfer = m_xfer + 16'd1;
                if (owner >= 0 && own_v && fifo_full && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                if (owner < 0) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        c = (last + k) % NUM_REQ;
                        if (owner < 0 && req_valid[IDW'(c)]) begin
                            owner = c; gid = c; beats = 0;
                        end
                    end
                end else if (!own_v) begin
                    last = owner; owner = -1;
                end else if (!fifo_full) begin
                    beats++;
                    if (beats == BURST_LEN) begin
                        last = owner; owner = -1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (dq[i].size() > 0) && !hold_off[i];
            if (dq[i].size() > 0) req_data[i*DATA_W +: DATA_W] = dq[i][0];
            else                  req_data[i*DATA_W +: DATA_W] = '0;
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (acc_mask[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        drive_inputs();
    endtask

    task automatic clear_logs();
        wr_log.delete(); gnt_log.delete(); rr_log.delete(); en_log.delete();
    endtask

    task automatic do_reset();
        wr_rst = 1'b1; fifo_full = 1'b0; hold_off = '0;
        for (int i = 0; i < NUM_REQ; i++) dq[i].delete();
        drive_inputs();
        step();
        step();
        wr_rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_writes(input string name, input int n, input int budget);
        int b = 0;
        while (wr_log.size() < n && b < budget) begin step(); b++; end
        if (wr_log.size() < n) check(name, 32'(wr_log.size()), 32'(n));
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        int b = 0;
        while (gnt_log.size() < n && b < budget) begin step(); b++; end
        if (gnt_log.size() < n) check(name, 32'(gnt_log.size()), 32'(n));
    endtask

    function automatic logic [31:0] en_bits(input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++)
            if (k < en_log.size()) v = {v[30:0], en_log[k]};
            else                   v = {v[30:0], 1'b0};
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        wr_rst = 1'b1; fifo_full = 1'b0; hold_off = '0;
        req_valid = '0; req_data = '0;

        // Reset then idle
        do_reset();
        repeat (3) step();
        #1;
        check("idle_wr_en",   32'(fifo_wr_en),  32'h0);
        check("idle_ready",   32'(req_ready),   32'h0);
        check("idle_gv",      32'(grant_valid), 32'h0);
        check("idle_gid",     32'(grant_id),    32'h0);
        check("idle_data",    32'(fifo_wr_data),32'h0);
        check("idle_state",   32'(dbg_state),   32'h0);
        check("idle_rr_ptr",  32'(dbg_rr_ptr),  32'h3);

        // Single requester, six beats: bubble, 4 writes, bubble, 2 writes
        do_reset();
        for (int k = 0; k < 6; k++) dq[0].push_back(8'(8'h11 + k));
        drive_inputs();
        repeat (12) step();
        check("single_en_pattern", en_bits(8), 32'h7B);
        check("single_wr_count",   32'(wr_log.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < wr_log.size()) check("single_data", 32'(wr_log[k]), 32'(8'h11 + k));
        check("single_grants", 32'(gnt_log.size()), 32'd2);
        for (int k = 0; k < gnt_log.size(); k++) check("single_gid", 32'(gnt_log[k]), 32'h0);

        // Round-robin with everyone valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) dq[i].push_back(8'(i*16 + k));
        drive_inputs();
        wait_grants("rr_wait", 5, 40);
        repeat (3) step();
        check("rr_en_pattern", en_bits(20), 32'h7BDEF);
        for (int k = 0; k < 5; k++)
            if (k < gnt_log.size()) check("rr_grant_order", 32'(gnt_log[k]), 32'(k % NUM_REQ));
        if (wr_log.size() > 12) begin
            check("rr_data_req1", 32'(wr_log[4]),  32'h10);
            check("rr_data_req3", 32'(wr_log[12]), 32'h30);
        end else check("rr_wr_count", 32'(wr_log.size()), 32'd13);

        // Full backpressure mid-burst on requester 2
        do_reset();
        for (int k = 0; k < 4; k++) dq[2].push_back(8'(8'h20 + k));
        drive_inputs();
        wait_writes("bp_wait_start", 2, 20);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_wr_en",  32'(fifo_wr_en),  32'h0);
            check("bp_ready",  32'(req_ready),   32'h0);
            check("bp_gid",    32'(grant_id),    32'h2);
            check("bp_gv",     32'(grant_valid), 32'h1);
            step();
        end
        fifo_full = 1'b0;
        wait_writes("bp_wait_resume", 4, 20);
        if (wr_log.size() >= 4) begin
            check("bp_data_beat3", 32'(wr_log[2]), 32'h22);
            check("bp_data_beat4", 32'(wr_log[3]), 32'h23);
        end
`ifdef ARB_STATS_EN
        check("bp_stall_count", 32'(stall_count), 32'd5);
`endif

        // Early release by requester 1 while requester 3 waits
        do_reset();
        dq[1].push_back(8'h31); dq[1].push_back(8'h32);
        for (int k = 0; k < 4; k++) dq[3].push_back(8'(8'h51 + k));
        drive_inputs();
        wait_grants("er_wait", 2, 30);
        check("er_en_pattern", en_bits(6), 32'h19);
        if (gnt_log.size() >= 2) begin
            check("er_first_gid",  32'(gnt_log[0]), 32'h1);
            check("er_second_gid", 32'(gnt_log[1]), 32'h3);
            check("er_rr_ptr",     32'(rr_log[1]),  32'h1);
        end

        // Reset on beat 2 of a 4-beat burst from requester 1
        do_reset();
        for (int k = 0; k < 4; k++) dq[1].push_back(8'(8'h61 + k));
        drive_inputs();
        wait_writes("mr_wait", 1, 20);
        wr_rst = 1'b1;
        dq[0].push_back(8'h71); dq[0].push_back(8'h72);
        drive_inputs();
        #1;
        check("mr_wr_en_in_reset", 32'(fifo_wr_en), 32'h0);
        check("mr_ready_in_reset", 32'(req_ready),  32'h0);
        step();
        wr_rst = 1'b0;
        gnt_log.delete();
`ifdef ARB_STATS_EN
        check("mr_xfer_count", 32'(xfer_count), 32'h0);
`endif
        wait_grants("mr_wait_grant", 1, 20);
        if (gnt_log.size() >= 1) check("mr_next_gid", 32'(gnt_log[0]), 32'h0);

        // Randomized traffic, backpressure, valid drops and occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 3) == 0 && dq[i].size() < 6)
                    dq[i].push_back(8'($urandom_range(0, 255)));
                hold_off[i] = ($urandom_range(0, 7) == 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            wr_rst    = ($urandom_range(0, 199) == 0);
            drive_inputs();
            step();
        end
        wr_rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
